twofive_tx: RTL and testbench
=============================

Name: twofive_tx

Overview:
- Upstream serializer for the 2-of-5 serial link. It accepts decimal digits over a valid/ready handshake, buffers them in a small FIFO, and encodes each one as a 5-bit 2-of-5 codeword.
- Drives one bit per clock, MSB first, into the downstream frame checker.
- Frame slots are free-running from reset, five cycles per frame, aligned with the checker's own frame counter.
- When no digit is queued at a frame boundary, it emits an idle frame.

Parameters:
DEPTH, 2, digit FIFO entries (1..8)
IDLE_CODE, 5'b00000, codeword sent when FIFO empty at frame load

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
dig_valid  input  1  digit offered
dig  input  4  BCD digit, 0..9 legal
dig_ready  output  1  digit accepted this cycle when dig_valid&&dig_ready
dig_err  output  1  one-cycle pulse: illegal digit (>9) was offered and dropped
level  output  $clog2(DEPTH+1)  FIFO occupancy
tx_bit  output  1  serial output bit
tx_last  output  1  high during slot 4 (fifth bit of frame)
tx_data  output  1  high for whole frame when frame carries a digit, low for idle

Behaviour:
- Reset values: slot=0, FIFO empty, shift register=IDLE_CODE, tx_data=0, dig_err=0, level=0. tx_bit=IDLE_CODE[4]. tx_last=0.
- Slot counter: 0..4, advances every clk, 4 wraps to 0. No stall; identical phase to the checker's counter out of reset.
- tx_bit = shift register MSB (registered, glitch-free). tx_last = (slot==4).
- At a posedge with slot!=4: shift register shifts left by 1.
- At a posedge with slot==4: shift register loads the next frame.
  - FIFO non-empty: pop head, load its codeword, tx_data<=1.
  - FIFO empty: load IDLE_CODE, tx_data<=0.
- First frame after reset is always idle.
- Codeword table (digit: bits, MSB first, weights 7-4-2-1-0):
  - 1:00011, 2:00101, 3:00110, 4:01001, 5:01010
  - 6:01100, 7:10001, 8:10010, 9:10100, 0:11000
  - Every legal codeword has exactly two ones.
- Handshake:
  - dig_ready = !full || (slot==4).
  - dig_ready never depends on dig_valid or dig.
  - Push and pop at the same edge are legal: level unchanged when full. A push into an empty FIFO at slot 4 is not bypassed; it is sent one frame later.
- Illegal digit (dig>9) with dig_valid&&dig_ready:
  - Handshake completes and the digit is consumed but not stored.
  - dig_err=1 for exactly the following cycle. level unchanged.
- level updates at the same edge as push/pop.
- Reset mid-frame: frame aborted immediately; FIFO contents discarded; state returns to the reset values.
- Latency: a digit accepted into an empty FIFO at slot s (s!=4) appears starting at the edge after the next slot-4 edge, i.e. 5-s cycles later.

Decomposition:
- Package twofive_pkg holds the shared link definitions, used by both this block and the checker:
  - FRAME_LEN=5
  - slot enum S0..S4
  - codeword type logic[4:0]
  - function digit_to_code (table above; returns IDLE for illegal input)
- Sub-module twofive_fifo: synchronous FIFO, parameter DEPTH, 4-bit data, push/pop/full/empty/level. It handles simultaneous push and pop when full.
- Top level contains the slot counter, load/shift register, and the error pulse.

Test Plan:
- Reset, no digits, 15 cycles -> tx_bit all 0, tx_data=0, tx_last high at cycles 4, 9, 14, dig_ready=1, level=0.
- Push digit 7 at cycle 0 -> level=1, then 0 at the edge ending cycle 4. Cycles 5..9 tx_bit=1,0,0,0,1 with tx_data=1. Checker valid=1 at cycle 9.
- Push 1,2,3 back-to-back from cycle 0 (DEPTH=2) -> third offer held with dig_ready=0 until slot 4, then accepted. Frames: 00011, 00101, 00110 in consecutive frames, no idle gap.
- Offer dig=12 at cycle 2 -> accepted, dig_err=1 in cycle 3 only, level stays 0, next frame idle.
- Full FIFO at slot 4 with dig_valid=1 -> push and pop on same edge, level stays 2, no digit lost or duplicated. Output order matches input order over 10 digits 0..9.
- Assert rst at slot 2 of a digit-0 frame with FIFO holding 2 entries -> tx_bit=0 immediately, level=0. After release, first frame idle and previously queued digits never transmitted.

Source files
------------

// File: rtl/twofive_pkg.sv
// Shared 2-of-5 link definitions for the serializer and the downstream frame checker.
package twofive_pkg;

   localparam int FRAME_LEN = 5;

   typedef enum logic [2:0] {S0, S1, S2, S3, S4} slot_t;
   typedef logic [4:0] codeword_t;

   localparam slot_t     LAST_SLOT = slot_t'(FRAME_LEN - 1);
   localparam codeword_t IDLE      = 5'b00000;

   // Weights 7-4-2-1-0, MSB first; illegal digits map to IDLE.
   function automatic codeword_t digit_to_code(input logic [3:0] d);
      codeword_t c;
      case (d)
         4'd0:    c = 5'b11000;
         4'd1:    c = 5'b00011;
         4'd2:    c = 5'b00101;
         4'd3:    c = 5'b00110;
         4'd4:    c = 5'b01001;
         4'd5:    c = 5'b01010;
         4'd6:    c = 5'b01100;
         4'd7:    c = 5'b10001;
         4'd8:    c = 5'b10010;
         4'd9:    c = 5'b10100;
         default: c = IDLE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/twofive_fifo.sv
// Small synchronous digit FIFO; a push into a full FIFO is accepted only alongside a pop.
module twofive_fifo #(
   parameter int DEPTH = 2,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [3:0]    wdata,
   output logic [3:0]    rdata,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [3:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/twofive_tx.sv
// 2-of-5 serializer: queues BCD digits and shifts one codeword per 5-cycle frame, MSB first.
module twofive_tx
   import twofive_pkg::*;
#(
   parameter int        DEPTH     = 2,
   parameter codeword_t IDLE_CODE = 5'b00000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         dig_valid,
   input  logic [3:0]                   dig,
   output logic                         dig_ready,
   output logic                         dig_err,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         tx_bit,
   output logic                         tx_last,
   output logic                         tx_data
);

   slot_t      slot;
   codeword_t  shreg;
   logic       full, empty;
   logic [3:0] head;
   logic       frame_end, accept, legal, push, pop;

   assign frame_end = (slot == LAST_SLOT);
   assign dig_ready = !full || frame_end;
   assign accept    = dig_valid && dig_ready;
   assign legal     = (dig <= 4'd9);
   assign push      = accept && legal;
   assign pop       = frame_end && !empty;

   assign tx_bit  = shreg[4];
   assign tx_last = frame_end;

   twofive_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (dig),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   // The frame load sees the FIFO before this edge's push, so a digit pushed
   // into an empty FIFO at the last slot waits a full frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot    <= S0;
         shreg   <= IDLE_CODE;
         tx_data <= 1'b0;
         dig_err <= 1'b0;
      end else begin
         slot    <= frame_end ? S0 : slot.next();
         dig_err <= accept && !legal;
         if (frame_end) begin
            if (!empty) begin
               shreg   <= digit_to_code(head);
               tx_data <= 1'b1;
            end else begin
               shreg   <= IDLE_CODE;
               tx_data <= 1'b0;
            end
         end else begin
            shreg <= {shreg[3:0], 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_twofive_tx.sv
// Directed bench for twofive_tx: idle stream, latency, back-pressure, illegal digits, ordering, reset abort.
module tb_twofive_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       dig_valid = 1'b0;
   logic [3:0] dig = 4'd0;
   logic       dig_ready, dig_err, tx_bit, tx_last, tx_data;
   logic [1:0] level;

   int checks = 0;
   int failures = 0;

   logic [4:0] exp_code [10];

   twofive_tx #(.DEPTH(2), .IDLE_CODE(5'b00000)) dut (
      .clk       (clk),
      .rst       (rst),
      .dig_valid (dig_valid),
      .dig       (dig),
      .dig_ready (dig_ready),
      .dig_err   (dig_err),
      .level     (level),
      .tx_bit    (tx_bit),
      .tx_last   (tx_last),
      .tx_data   (tx_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds reset across one edge, checks reset values, releases mid-cycle: caller is then in cycle 0.
   task automatic do_reset();
      dig_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_tx_bit", tx_bit, 0);
      chk("rst_tx_last", tx_last, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_dig_err", dig_err, 0);
      chk("rst_level", level, 0);
      rst = 1'b0;
   endtask

   task automatic expect_frame(input string tag, input logic [4:0] code, input logic data);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("%s_bit%0d", tag, i), tx_bit, code[4-i]);
         chk($sformatf("%s_data%0d", tag, i), tx_data, data);
         chk($sformatf("%s_last%0d", tag, i), tx_last, (i == 4));
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_code[0] = 5'b11000; exp_code[1] = 5'b00011; exp_code[2] = 5'b00101;
      exp_code[3] = 5'b00110; exp_code[4] = 5'b01001; exp_code[5] = 5'b01010;
      exp_code[6] = 5'b01100; exp_code[7] = 5'b10001; exp_code[8] = 5'b10010;
      exp_code[9] = 5'b10100;

      // idle stream
      do_reset();
      for (int c = 0; c < 15; c++) begin
         chk($sformatf("idle_bit_c%0d", c), tx_bit, 0);
         chk($sformatf("idle_data_c%0d", c), tx_data, 0);
         chk($sformatf("idle_last_c%0d", c), tx_last, (c % 5 == 4));
         chk($sformatf("idle_ready_c%0d", c), dig_ready, 1);
         chk($sformatf("idle_level_c%0d", c), level, 0);
         tick();
      end

      // single digit 7 at cycle 0
      do_reset();
      dig_valid = 1'b1; dig = 4'd7;
      chk("d7_ready", dig_ready, 1);
      tick();
      dig_valid = 1'b0;
      for (int c = 1; c < 5; c++) begin
         chk($sformatf("d7_level_c%0d", c), level, 1);
         tick();
      end
      chk("d7_level_c5", level, 0);
      expect_frame("d7", 5'b10001, 1'b1);
      expect_frame("d7_after", 5'b00000, 1'b0);

      // back-pressure with DEPTH=2
      do_reset();
      dig_valid = 1'b1; dig = 4'd1;
      chk("bp_ready_c0", dig_ready, 1);
      tick();
      dig = 4'd2;
      chk("bp_ready_c1", dig_ready, 1);
      tick();
      dig = 4'd3;
      chk("bp_ready_c2", dig_ready, 0);
      chk("bp_level_c2", level, 2);
      tick();
      chk("bp_ready_c3", dig_ready, 0);
      tick();
      chk("bp_ready_c4", dig_ready, 1);
      tick();
      dig_valid = 1'b0;
      chk("bp_level_c5", level, 2);
      expect_frame("bp_f1", 5'b00011, 1'b1);
      chk("bp_level_c10", level, 1);
      expect_frame("bp_f2", 5'b00101, 1'b1);
      chk("bp_level_c15", level, 0);
      expect_frame("bp_f3", 5'b00110, 1'b1);
      expect_frame("bp_f4", 5'b00000, 1'b0);

      // illegal digit 12 at cycle 2
      do_reset();
      tick();
      tick();
      dig_valid = 1'b1; dig = 4'd12;
      chk("ill_ready_c2", dig_ready, 1);
      chk("ill_err_c2", dig_err, 0);
      tick();
      dig_valid = 1'b0;
      chk("ill_err_c3", dig_err, 1);
      chk("ill_level_c3", level, 0);
      tick();
      chk("ill_err_c4", dig_err, 0);
      chk("ill_level_c4", level, 0);
      tick();
      expect_frame("ill_f1", 5'b00000, 1'b0);

      // streaming 0..9 with full FIFO push+pop at frame boundaries
      begin
         int nd;
         nd = 0;
         do_reset();
         for (int c = 0; c < 60; c++) begin
            int f, i;
            dig_valid = (nd < 10);
            dig = 4'(nd);
            if (c >= 5) begin
               f = (c - 5) / 5;
               i = (c - 5) % 5;
               chk($sformatf("seq_bit_c%0d", c), tx_bit, (f < 10) ? exp_code[f][4-i] : 1'b0);
               chk($sformatf("seq_data_c%0d", c), tx_data, (f < 10));
            end
            if (c >= 5 && c <= 40 && (c % 5 == 0))
               chk($sformatf("seq_level_c%0d", c), level, 2);
            if (dig_valid && dig_ready) nd++;
            tick();
         end
         dig_valid = 1'b0;
         chk("seq_accepted", nd, 10);
      end

      // reset in slot 2 of a digit-0 frame with two digits queued
      do_reset();
      dig_valid = 1'b1; dig = 4'd0;
      tick();
      dig = 4'd5;
      tick();
      dig_valid = 1'b0;
      tick();
      tick();
      dig_valid = 1'b1; dig = 4'd6;
      tick();
      dig_valid = 1'b0;
      chk("abort_level_c5", level, 2);
      chk("abort_bit_c5", tx_bit, 1);
      tick();
      chk("abort_bit_c6", tx_bit, 1);
      tick();
      chk("abort_data_c7", tx_data, 1);
      rst = 1'b1;
      #1;
      chk("abort_bit", tx_bit, 0);
      chk("abort_data", tx_data, 0);
      chk("abort_level", level, 0);
      chk("abort_ready", dig_ready, 1);
      chk("abort_last", tx_last, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      expect_frame("abort_f1", 5'b00000, 1'b0);
      expect_frame("abort_f2", 5'b00000, 1'b0);
      expect_frame("abort_f3", 5'b00000, 1'b0);
      chk("abort_level_end", level, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
